// File: rtl/tri_port_regfile_ctrl_pkg.sv
// rtl/tri_port_regfile_ctrl_pkg.sv - shared state encoding, op codes and response defaults
package tri_port_regfile_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CAM,
    ST_CAM_CHK,
    ST_WRITE,
    ST_READ,
    ST_READ_CHK,
    ST_RESP
  } ctrl_state_t;

  localparam logic OP_LOOKUP = 1'b0;
  localparam logic OP_READ   = 1'b1;

  localparam logic RESP_HIT_DEFAULT   = 1'b0;
  localparam logic RESP_EVICT_DEFAULT = 1'b0;
  localparam logic RESP_ERROR_DEFAULT = 1'b0;

endpackage

// File: rtl/find_first_one_decoded.sv
// rtl/find_first_one_decoded.sv - one-hot select of the lowest set bit of a vector
module find_first_one_decoded #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] vec,
  output logic [WIDTH-1:0] onehot
);

  // Two's complement isolates the lowest set bit; an all-zero input yields zero.
  assign onehot = vec & (-vec);

endmodule

// File: rtl/tri_port_regfile_ctrl.sv
// rtl/tri_port_regfile_ctrl.sv - lookup-or-insert / read-by-index sequencer for a tri-port regfile tag store
module tri_port_regfile_ctrl
  import tri_port_regfile_ctrl_pkg::*;
#(
  parameter int SINGLE_ENTRY_SIZE_IN_BITS = 8,
  parameter int NUMBER_ENTRY              = 4
) (
  input  logic                                 clk_in,
  input  logic                                 reset_in,
  input  logic                                 req_valid_in,
  output logic                                 req_ready_out,
  input  logic                                 req_op_in,
  input  logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0] req_key_in,
  input  logic [NUMBER_ENTRY-1:0]              req_index_decoded_in,
  output logic                                 resp_valid_out,
  input  logic                                 resp_ready_in,
  output logic                                 resp_hit_out,
  output logic                                 resp_evict_out,
  output logic                                 resp_error_out,
  output logic [NUMBER_ENTRY-1:0]              resp_index_decoded_out,
  output logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0] resp_data_out,
  output logic                                 rf_read_en_out,
  output logic                                 rf_write_en_out,
  output logic                                 rf_cam_en_out,
  output logic [NUMBER_ENTRY-1:0]              rf_read_entry_addr_decoded_out,
  output logic [NUMBER_ENTRY-1:0]              rf_write_entry_addr_decoded_out,
  output logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0] rf_cam_entry_out,
  output logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0] rf_write_entry_out,
  input  logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0] rf_read_entry_in,
  input  logic [NUMBER_ENTRY-1:0]              rf_cam_result_decoded_in,
  input  logic [NUMBER_ENTRY-1:0]              rf_entry_valid_flatted_in
);

  localparam int W = SINGLE_ENTRY_SIZE_IN_BITS;
  localparam int N = NUMBER_ENTRY;

  ctrl_state_t  state;
  logic [N-1:0] rr_ptr;
  logic [W-1:0] key_q;
  logic [N-1:0] idx_q;
  logic [N-1:0] victim_q;
  logic         evict_q;
  logic         ready_q;

  logic         rf_read_en_q, rf_write_en_q, rf_cam_en_q;
  logic [N-1:0] rf_read_addr_q, rf_write_addr_q;
  logic [W-1:0] rf_cam_entry_q, rf_write_entry_q;

  logic         resp_valid_q, resp_hit_q, resp_evict_q, resp_error_q;
  logic [N-1:0] resp_index_q;
  logic [W-1:0] resp_data_q;

  logic [N-1:0] idx_norm, hits, hit_sel, free_sel;
  logic         rd_err;

  assign hits   = rf_cam_result_decoded_in & rf_entry_valid_flatted_in;
  // A zero index also lands here, since its normalised form masks to nothing.
  assign rd_err = (idx_norm & rf_entry_valid_flatted_in) == '0;

  find_first_one_decoded #(.WIDTH(N)) u_ffo_idx  (.vec(req_index_decoded_in),       .onehot(idx_norm));
  find_first_one_decoded #(.WIDTH(N)) u_ffo_hit  (.vec(hits),                       .onehot(hit_sel));
  find_first_one_decoded #(.WIDTH(N)) u_ffo_free (.vec(~rf_entry_valid_flatted_in), .onehot(free_sel));

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      state            <= ST_IDLE;
      rr_ptr           <= N'(1);
      key_q            <= '0;
      idx_q            <= '0;
      victim_q         <= '0;
      evict_q          <= 1'b0;
      ready_q          <= 1'b1;
      rf_read_en_q     <= 1'b0;
      rf_write_en_q    <= 1'b0;
      rf_cam_en_q      <= 1'b0;
      rf_read_addr_q   <= '0;
      rf_write_addr_q  <= '0;
      rf_cam_entry_q   <= '0;
      rf_write_entry_q <= '0;
      resp_valid_q     <= 1'b0;
      resp_hit_q       <= RESP_HIT_DEFAULT;
      resp_evict_q     <= RESP_EVICT_DEFAULT;
      resp_error_q     <= RESP_ERROR_DEFAULT;
      resp_index_q     <= '0;
      resp_data_q      <= '0;
    end else begin
      // Regfile strobes are single-cycle: set on entry to the state that owns them.
      rf_read_en_q     <= 1'b0;
      rf_write_en_q    <= 1'b0;
      rf_cam_en_q      <= 1'b0;
      rf_read_addr_q   <= '0;
      rf_write_addr_q  <= '0;
      rf_cam_entry_q   <= '0;
      rf_write_entry_q <= '0;
      case (state)
        ST_IDLE: begin
          if (req_valid_in) begin
            ready_q <= 1'b0;
            key_q   <= req_key_in;
            idx_q   <= idx_norm;
            if (req_op_in == OP_LOOKUP) begin
              state          <= ST_CAM;
              rf_cam_en_q    <= 1'b1;
              rf_cam_entry_q <= req_key_in;
            end else if (rd_err) begin
              state        <= ST_RESP;
              resp_valid_q <= 1'b1;
              resp_hit_q   <= RESP_HIT_DEFAULT;
              resp_evict_q <= RESP_EVICT_DEFAULT;
              resp_error_q <= 1'b1;
              resp_index_q <= '0;
              resp_data_q  <= '0;
            end else begin
              state          <= ST_READ;
              rf_read_en_q   <= 1'b1;
              rf_read_addr_q <= idx_norm;
            end
          end
        end
        ST_CAM: state <= ST_CAM_CHK;
        ST_CAM_CHK: begin
          if (hits != '0) begin
            state        <= ST_RESP;
            resp_valid_q <= 1'b1;
            resp_hit_q   <= 1'b1;
            resp_evict_q <= RESP_EVICT_DEFAULT;
            resp_error_q <= RESP_ERROR_DEFAULT;
            resp_index_q <= hit_sel;
            resp_data_q  <= '0;
          end else begin
            state            <= ST_WRITE;
            rf_write_en_q    <= 1'b1;
            rf_write_entry_q <= key_q;
            if (free_sel != '0) begin
              rf_write_addr_q <= free_sel;
              victim_q        <= free_sel;
              evict_q         <= 1'b0;
            end else begin
              rf_write_addr_q <= rr_ptr;
              victim_q        <= rr_ptr;
              evict_q         <= 1'b1;
              rr_ptr          <= {rr_ptr[N-2:0], rr_ptr[N-1]};
            end
          end
        end
        ST_WRITE: begin
          state        <= ST_RESP;
          resp_valid_q <= 1'b1;
          resp_hit_q   <= RESP_HIT_DEFAULT;
          resp_evict_q <= evict_q;
          resp_error_q <= RESP_ERROR_DEFAULT;
          resp_index_q <= victim_q;
          resp_data_q  <= '0;
        end
        ST_READ: state <= ST_READ_CHK;
        ST_READ_CHK: begin
          state        <= ST_RESP;
          resp_valid_q <= 1'b1;
          resp_hit_q   <= RESP_HIT_DEFAULT;
          resp_evict_q <= RESP_EVICT_DEFAULT;
          resp_error_q <= RESP_ERROR_DEFAULT;
          resp_index_q <= idx_q;
          resp_data_q  <= rf_read_entry_in;
        end
        ST_RESP: begin
          if (resp_ready_in) begin
            state        <= ST_IDLE;
            ready_q      <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_hit_q   <= RESP_HIT_DEFAULT;
            resp_evict_q <= RESP_EVICT_DEFAULT;
            resp_error_q <= RESP_ERROR_DEFAULT;
            resp_index_q <= '0;
            resp_data_q  <= '0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Reset must silence every output in the very cycle it is raised, including a pending write.
  logic live;
  assign live = ~reset_in;

  assign req_ready_out                   = ready_q & live;
  assign resp_valid_out                  = resp_valid_q & live;
  assign resp_hit_out                    = resp_hit_q & live;
  assign resp_evict_out                  = resp_evict_q & live;
  assign resp_error_out                  = resp_error_q & live;
  assign resp_index_decoded_out          = resp_index_q & {N{live}};
  assign resp_data_out                   = resp_data_q & {W{live}};
  assign rf_read_en_out                  = rf_read_en_q & live;
  assign rf_write_en_out                 = rf_write_en_q & live;
  assign rf_cam_en_out                   = rf_cam_en_q & live;
  assign rf_read_entry_addr_decoded_out  = rf_read_addr_q & {N{live}};
  assign rf_write_entry_addr_decoded_out = rf_write_addr_q & {N{live}};
  assign rf_cam_entry_out                = rf_cam_entry_q & {W{live}};
  assign rf_write_entry_out              = rf_write_entry_q & {W{live}};

endmodule

// File: tb/tb_tri_port_regfile_ctrl.sv
// tb/tb_tri_port_regfile_ctrl.sv - table-driven scoreboard bench with a behavioural tri-port regfile
module tb_tri_port_regfile_ctrl;

  localparam int W = 8;
  localparam int N = 4;

  logic         clk = 1'b0;
  logic         reset_in;
  logic         req_valid, req_ready, req_op, resp_ready;
  logic [W-1:0] req_key;
  logic [N-1:0] req_idx;
  logic         resp_valid, resp_hit, resp_evict, resp_error;
  logic [N-1:0] resp_idx;
  logic [W-1:0] resp_data;
  logic         rf_read_en, rf_write_en, rf_cam_en;
  logic [N-1:0] rf_rd_addr, rf_wr_addr;
  logic [W-1:0] rf_cam_key, rf_wr_data;
  logic [W-1:0] rf_rd_data = '0;
  logic [N-1:0] rf_cam_res = '0;
  logic [N-1:0] rf_valid   = '0;
  logic [W-1:0] mem [N];

  always #5 clk = ~clk;

  tri_port_regfile_ctrl #(.SINGLE_ENTRY_SIZE_IN_BITS(W), .NUMBER_ENTRY(N)) dut (
    .clk_in(clk), .reset_in(reset_in),
    .req_valid_in(req_valid), .req_ready_out(req_ready), .req_op_in(req_op),
    .req_key_in(req_key), .req_index_decoded_in(req_idx),
    .resp_valid_out(resp_valid), .resp_ready_in(resp_ready),
    .resp_hit_out(resp_hit), .resp_evict_out(resp_evict), .resp_error_out(resp_error),
    .resp_index_decoded_out(resp_idx), .resp_data_out(resp_data),
    .rf_read_en_out(rf_read_en), .rf_write_en_out(rf_write_en), .rf_cam_en_out(rf_cam_en),
    .rf_read_entry_addr_decoded_out(rf_rd_addr), .rf_write_entry_addr_decoded_out(rf_wr_addr),
    .rf_cam_entry_out(rf_cam_key), .rf_write_entry_out(rf_wr_data),
    .rf_read_entry_in(rf_rd_data), .rf_cam_result_decoded_in(rf_cam_res),
    .rf_entry_valid_flatted_in(rf_valid)
  );

  // Behavioural regfile: registered read and CAM results, writes visible next cycle.
  function automatic logic [W-1:0] rd_mux(input logic [N-1:0] a);
    logic [W-1:0] r = '0;
    for (int i = 0; i < N; i++) if (a[i]) r = r | mem[i];
    return r;
  endfunction

  function automatic logic [N-1:0] cam_match(input logic [W-1:0] k);
    logic [N-1:0] r = '0;
    for (int i = 0; i < N; i++) r[i] = (mem[i] == k);
    return r;
  endfunction

  initial for (int i = 0; i < N; i++) mem[i] = '0;

  always @(posedge clk) begin
    if (rf_write_en)
      for (int i = 0; i < N; i++)
        if (rf_wr_addr[i]) begin
          mem[i]      <= rf_wr_data;
          rf_valid[i] <= 1'b1;
        end
    if (rf_read_en) rf_rd_data <= rd_mux(rf_rd_addr);
    if (rf_cam_en)  rf_cam_res <= cam_match(rf_cam_key);
  end

  typedef struct {
    logic         op;
    logic [W-1:0] key;
    logic [N-1:0] idx;
    logic         hit, evict, err;
    logic [N-1:0] exp_idx;
    logic [W-1:0] exp_data;
    int           lat;
    logic         exp_wr, exp_rd;
  } vec_t;

  typedef struct {
    logic         hit, evict, err;
    logic [N-1:0] idx;
    logic [W-1:0] data;
  } resp_t;

  vec_t  tbl[$];
  resp_t sb[$];
  int    n_cmp = 0;
  int    n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input int n, input vec_t v);
    resp_t        e, a;
    int           lat;
    logic         got, saw_wr, saw_rd;
    logic [N-1:0] wa;
    logic [W-1:0] wd;
    @(negedge clk);
    chk($sformatf("v%0d_req_ready", n), req_ready, 1);
    req_valid = 1'b1; req_op = v.op; req_key = v.key; req_idx = v.idx;
    e.hit = v.hit; e.evict = v.evict; e.err = v.err; e.idx = v.exp_idx; e.data = v.exp_data;
    sb.push_back(e);
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 0; got = 1'b0; saw_wr = 1'b0; saw_rd = 1'b0; wa = '0; wd = '0;
    while (!got && lat < 20) begin
      @(negedge clk);
      lat++;
      if (rf_write_en) begin saw_wr = 1'b1; wa = rf_wr_addr; wd = rf_wr_data; end
      if (rf_read_en) saw_rd = 1'b1;
      if (resp_valid) got = 1'b1;
    end
    e = sb.pop_front();
    if (!got) begin
      chk($sformatf("v%0d_resp_timeout", n), 0, 1);
    end else begin
      a.hit = resp_hit; a.evict = resp_evict; a.err = resp_error; a.idx = resp_idx; a.data = resp_data;
      chk($sformatf("v%0d_hit", n), a.hit, e.hit);
      chk($sformatf("v%0d_evict", n), a.evict, e.evict);
      chk($sformatf("v%0d_error", n), a.err, e.err);
      chk($sformatf("v%0d_index", n), a.idx, e.idx);
      chk($sformatf("v%0d_data", n), a.data, e.data);
      chk($sformatf("v%0d_latency", n), lat, v.lat);
      chk($sformatf("v%0d_rf_write_seen", n), saw_wr, v.exp_wr);
      chk($sformatf("v%0d_rf_read_seen", n), saw_rd, v.exp_rd);
      if (v.exp_wr) begin
        chk($sformatf("v%0d_rf_write_addr", n), wa, v.exp_idx);
        chk($sformatf("v%0d_rf_write_data", n), wd, v.key);
      end
    end
  endtask

  initial begin
    int   lat;
    logic got;
    reset_in = 1'b1; req_valid = 1'b0; req_op = 1'b0; req_key = '0; req_idx = '0; resp_ready = 1'b1;

    //         op  key    idx      hit ev  err exp_idx  data   lat wr  rd
    tbl.push_back('{1'b0, 8'hA5, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0001, 8'h00, 4, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 8'hA5, 4'b0000, 1'b1, 1'b0, 1'b0, 4'b0001, 8'h00, 3, 1'b0, 1'b0});
    tbl.push_back('{1'b1, 8'h00, 4'b0010, 1'b0, 1'b0, 1'b1, 4'b0000, 8'h00, 1, 1'b0, 1'b0});
    tbl.push_back('{1'b1, 8'h00, 4'b0000, 1'b0, 1'b0, 1'b1, 4'b0000, 8'h00, 1, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 8'h11, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0010, 8'h00, 4, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 8'h22, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0100, 8'h00, 4, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 8'h33, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b1000, 8'h00, 4, 1'b1, 1'b0});
    tbl.push_back('{1'b1, 8'h00, 4'b0100, 1'b0, 1'b0, 1'b0, 4'b0100, 8'h22, 3, 1'b0, 1'b1});
    tbl.push_back('{1'b1, 8'h00, 4'b1000, 1'b0, 1'b0, 1'b0, 4'b1000, 8'h33, 3, 1'b0, 1'b1});
    tbl.push_back('{1'b0, 8'h44, 4'b0000, 1'b0, 1'b1, 1'b0, 4'b0001, 8'h00, 4, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 8'h55, 4'b0000, 1'b0, 1'b1, 1'b0, 4'b0010, 8'h00, 4, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 8'h44, 4'b0000, 1'b1, 1'b0, 1'b0, 4'b0001, 8'h00, 3, 1'b0, 1'b0});
    tbl.push_back('{1'b1, 8'h00, 4'b0110, 1'b0, 1'b0, 1'b0, 4'b0010, 8'h55, 3, 1'b0, 1'b1});
    tbl.push_back('{1'b0, 8'h33, 4'b0000, 1'b1, 1'b0, 1'b0, 4'b1000, 8'h00, 3, 1'b0, 1'b0});

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_req_ready", req_ready, 0);
    chk("reset_rf_enables", {rf_read_en, rf_write_en, rf_cam_en}, 0);
    chk("reset_resp_valid", resp_valid, 0);
    reset_in = 1'b0;
    #1;
    chk("post_reset_req_ready", req_ready, 1);
    chk("post_reset_resp", {resp_valid, resp_hit, resp_evict, resp_error, resp_idx, resp_data}, 0);

    for (int i = 0; i < tbl.size(); i++) run_vec(i, tbl[i]);

    // Stalled response while a second request waits behind it.
    @(negedge clk);
    resp_ready = 1'b0;
    req_valid = 1'b1; req_op = 1'b0; req_key = 8'h33; req_idx = '0;
    @(posedge clk);
    #1 req_op = 1'b1; req_key = '0; req_idx = 4'b0001;
    got = 1'b0;
    for (int c = 0; c < 10 && !got; c++) begin
      @(negedge clk);
      got = resp_valid;
    end
    chk("stall_resp_seen", got, 1);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk($sformatf("stall%0d_fields", c), {resp_valid, resp_hit, resp_evict, resp_error, resp_idx}, {4'b1100, 4'b1000});
      chk($sformatf("stall%0d_req_ready", c), req_ready, 0);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    chk("stall_after_hs_resp_valid", resp_valid, 0);
    chk("stall_after_hs_req_ready", req_ready, 1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 0; got = 1'b0;
    while (!got && lat < 20) begin
      @(negedge clk);
      lat++;
      got = resp_valid;
    end
    chk("second_req_latency", lat, 3);
    chk("second_req_data", resp_data, 8'h44);
    chk("second_req_index", resp_idx, 4'b0001);

    // Reset during the WRITE of an evicting miss (pointer sits at 0100 here).
    @(negedge clk);
    req_valid = 1'b1; req_op = 1'b0; req_key = 8'h66; req_idx = '0;
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("abort_in_write_state", rf_write_en, 1);
    reset_in = 1'b1;
    #1;
    chk("abort_write_en_dropped", rf_write_en, 0);
    chk("abort_write_addr_zero", rf_wr_addr, 0);
    @(negedge clk);
    reset_in = 1'b0;
    #1;
    chk("abort_req_ready", req_ready, 1);
    got = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      got = got | resp_valid;
    end
    chk("abort_no_resp", got, 0);
    run_vec(100, '{1'b0, 8'h77, 4'b0000, 1'b0, 1'b1, 1'b0, 4'b0001, 8'h00, 4, 1'b1, 1'b0});
    run_vec(101, '{1'b1, 8'h00, 4'b0100, 1'b0, 1'b0, 1'b0, 4'b0100, 8'h22, 3, 1'b0, 1'b1});

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
